router_fifo: RTL and testbench
==============================

ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of storage entries (power of two, 4 to 64).
REQ-002 SHALL have parameter WIDTH, default 8, data byte width.
REQ-003 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port soft_reset  in  1  synchronous flush from the sync/timeout logic, active-high.
REQ-006 SHALL have port write_enb  in  1  push request for this output port.
REQ-007 SHALL have port read_enb  in  1  pop request from the destination.
REQ-008 SHALL have port lfd_state  in  1  marks data_in as packet header byte.
REQ-009 SHALL have port data_in  in  WIDTH  byte to store.
REQ-010 SHALL have port data_out  out  WIDTH  registered read data.
REQ-011 SHALL have port full  out  1  no free entry.
REQ-012 SHALL have port empty  out  1  no stored entry.

Function
REQ-013 SHALL store each entry as WIDTH+1 bits: {lfd_state, data_in}.
REQ-014 SHALL use write and read pointers of log2(DEPTH)+1 bits, incrementing modulo 2*DEPTH; wrap-around requires no special case.
REQ-015 SHALL drive empty = (wr_ptr == rd_ptr) and full = (MSBs differ, low bits equal), combinationally from pointers.
REQ-016 SHALL on write_enb && !full store the entry at wr_ptr and increment wr_ptr; write_enb while full is dropped, no state change.
REQ-017 SHALL on read_enb && !empty load data_out with the byte at rd_ptr on the same edge (1-cycle latency) and increment rd_ptr; read_enb while empty is ignored.
REQ-018 SHALL perform simultaneous accepted write and read in one cycle; occupancy unchanged; full/empty evaluated on pre-edge pointers.
REQ-019 SHALL keep a 6-bit packet counter pkt_cnt: a popped entry with header flag set loads pkt_cnt = data[7:2] + 1 (payload plus parity byte).
REQ-020 SHALL decrement pkt_cnt by one on each popped non-header entry while pkt_cnt != 0; never decrement below 0.
REQ-021 SHALL clear data_out to 0 on any edge where pkt_cnt == 0 and no read is accepted; otherwise data_out holds between reads.
REQ-022 SHALL with soft_reset asserted clear both pointers, pkt_cnt and data_out to 0 on that edge, overriding any write or read in the same cycle.

Reset
REQ-023 SHALL on reset clear wr_ptr, rd_ptr, pkt_cnt, data_out to 0; outputs after reset: empty=1, full=0, data_out=0.
REQ-024 SHALL give reset priority over soft_reset, and both over write/read.
REQ-025 SHALL NOT require storage array contents to be reset.
REQ-026 SHALL reset mid-packet, discarding all stored bytes; the next accepted write lands at entry 0.

Structure
REQ-027 SHALL place DEPTH/WIDTH defaults, the header length field position [7:2] and the packet-counter width in the shared router package.
REQ-028 SHALL be a single module; three instances (one per output port) are wired by the router top to write_enb[2:0], read_enb_0..2, soft_reset_0..2, full_0..2, empty_0..2.

Verification
REQ-029 Reset, then 16 writes of 0x10..0x1F, no reads -> full=1 after 16th edge, 17th write ignored, empty=0.
REQ-030 From full, read 16 times -> data_out 0x10..0x1F in order, one cycle after each read_enb, empty=1 after last.
REQ-031 Write header 0x0C (lfd=1, length 3) plus 4 bytes, read all 5 -> pkt_cnt loads 4, reaches 0 after parity byte, data_out=0 next idle cycle.
REQ-032 Occupancy 8, assert write_enb and read_enb together for 20 cycles -> occupancy stays 8, ordering preserved across pointer wrap.
REQ-033 Occupancy 5, assert soft_reset with write_enb=1 -> next cycle empty=1, data_out=0, written byte discarded.
REQ-034 Read while empty and write while full -> no pointer change, data_out unchanged except REQ-021 clear.

Source files
------------

// File: rtl/router_fifo_pkg.sv
// Shared router constants: FIFO geometry defaults, header length field and
// packet-counter sizing used by each output-port FIFO.
package router_fifo_pkg;

  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned FIFO_WIDTH  = 8;
  localparam int unsigned HDR_LEN_MSB = 7;
  localparam int unsigned HDR_LEN_LSB = 2;
  localparam int unsigned PKT_CNT_W   = 6;

  typedef logic [PKT_CNT_W-1:0] pkt_cnt_t;

  // Bytes still to leave after a header: payload length plus the parity byte.
  function automatic pkt_cnt_t hdr_pkt_len(input logic [HDR_LEN_MSB-HDR_LEN_LSB:0] len);
    return pkt_cnt_t'(len) + pkt_cnt_t'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for one output-port FIFO: synchronous write, combinational read.
module router_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 9
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] storage [DEPTH];

  always_ff @(posedge clk) begin
    if (we) storage[waddr] <= wdata;
  end

  assign rdata = storage[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-output-port router FIFO: stores {header flag, byte}, tracks packet length
// on the read side and zeroes data_out once a packet has fully drained.
module router_fifo
  import router_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [WIDTH:0] rd_entry;
  pkt_cnt_t       pkt_cnt;
  logic           wr_fire;
  logic           rd_fire;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_fire = write_enb && !full;
  assign rd_fire = read_enb && !empty;

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (WIDTH + 1)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire && !reset && !soft_reset),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({lfd_state, data_in}),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset || soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      data_out <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_entry[WIDTH-1:0];
        if (rd_entry[WIDTH])
          pkt_cnt <= hdr_pkt_len(rd_entry[HDR_LEN_MSB:HDR_LEN_LSB]);
        else if (pkt_cnt != '0)
          pkt_cnt <= pkt_cnt - 1'b1;
      end else if (pkt_cnt == '0) begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Directed scoreboard bench for router_fifo: each driven cycle queues its
// hand-computed post-edge expectation; a negedge monitor pops and compares.
module tb_router_fifo;

  logic       clk = 1'b0;
  logic       reset, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       full, empty;

  always #5 clk = ~clk;

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  typedef struct {
    int         tag;
    logic [7:0] dout;
    logic       emp;
    logic       ful;
    int         pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic string tname(input int t);
    case (t)
      0:       return "reset";
      1:       return "fill";
      2:       return "drain";
      3:       return "rd_empty";
      4:       return "pkt";
      5:       return "wrap";
      6:       return "soft_rst";
      7:       return "mid_rst";
      default: return "misc";
    endcase
  endfunction

  task automatic chk(input int tag, input string what, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s.%s actual=0x%0h expected=0x%0h at %0t", tname(tag), what, act, exp, $time);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, "data_out", int'(data_out), int'(e.dout));
      chk(e.tag, "empty",    int'(empty),    int'(e.emp));
      chk(e.tag, "full",     int'(full),     int'(e.ful));
      if (e.pc >= 0) chk(e.tag, "pkt_cnt", int'(dut.pkt_cnt), e.pc);
    end
  end

  // Drive one cycle and queue what the outputs must show after that edge.
  task automatic cyc(input int tag, input logic rst, input logic srst,
                     input logic we, input logic re, input logic lfd,
                     input logic [7:0] din, input logic [7:0] edout,
                     input logic eemp, input logic efull, input int epc);
    exp_t x;
    reset      = rst;
    soft_reset = srst;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    @(posedge clk);
    x.tag = tag; x.dout = edout; x.emp = eemp; x.ful = efull; x.pc = epc;
    exp_q.push_back(x);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    #1;
    // Reset, including reset with soft_reset and a write pending.
    cyc(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);
    cyc(0, 1, 1, 1, 1, 0, 8'hAB, 8'h00, 1, 0, 0);

    // Fill 16 entries; 17th write dropped.
    for (int i = 0; i < 16; i++)
      cyc(1, 0, 0, 1, 0, 0, 8'(8'h10 + i), 8'h00, 0, (i == 15), 0);
    cyc(1, 0, 0, 1, 0, 0, 8'h99, 8'h00, 0, 1, 0);

    // Drain in order, one-cycle read latency.
    for (int i = 0; i < 16; i++)
      cyc(2, 0, 0, 0, 1, 0, 8'h00, 8'(8'h10 + i), (i == 15), 0, 0);

    // Read while empty: ignored, data_out cleared since pkt_cnt is 0.
    cyc(3, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
    cyc(3, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0);

    // Header 0x0C (length 3) + 3 payload + parity.
    cyc(4, 0, 0, 1, 0, 1, 8'h0C, 8'h00, 0, 0, 0);
    cyc(4, 0, 0, 1, 0, 0, 8'hA1, 8'h00, 0, 0, 0);
    cyc(4, 0, 0, 1, 0, 0, 8'hA2, 8'h00, 0, 0, 0);
    cyc(4, 0, 0, 1, 0, 0, 8'hA3, 8'h00, 0, 0, 0);
    cyc(4, 0, 0, 1, 0, 0, 8'hA4, 8'h00, 0, 0, 0);
    cyc(4, 0, 0, 0, 1, 0, 8'h00, 8'h0C, 0, 0, 4);
    cyc(4, 0, 0, 0, 1, 0, 8'h00, 8'hA1, 0, 0, 3);
    cyc(4, 0, 0, 0, 0, 0, 8'h00, 8'hA1, 0, 0, 3);
    cyc(4, 0, 0, 0, 1, 0, 8'h00, 8'hA2, 0, 0, 2);
    cyc(4, 0, 0, 0, 1, 0, 8'h00, 8'hA3, 0, 0, 1);
    cyc(4, 0, 0, 0, 1, 0, 8'h00, 8'hA4, 1, 0, 0);
    cyc(4, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0);

    // Occupancy 8, then 20 simultaneous write+read cycles across the wrap.
    for (int i = 0; i < 8; i++)
      cyc(5, 0, 0, 1, 0, 0, 8'(8'h40 + i), 8'h00, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc(5, 0, 0, 1, 1, 0, 8'(8'h48 + i), 8'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < 8; i++)
      cyc(5, 0, 0, 0, 1, 0, 8'h00, 8'(8'h54 + i), (i == 7), 0, 0);

    // Occupancy 5 with a header popped, then soft_reset overriding write+read.
    cyc(6, 0, 0, 1, 0, 1, 8'h60, 8'h00, 0, 0, 0);
    for (int i = 1; i < 5; i++)
      cyc(6, 0, 0, 1, 0, 0, 8'(8'h60 + i), 8'h00, 0, 0, 0);
    cyc(6, 0, 0, 0, 1, 0, 8'h00, 8'h60, 0, 0, 25);
    cyc(6, 0, 1, 1, 1, 0, 8'hEE, 8'h00, 1, 0, 0);
    cyc(6, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
    cyc(6, 0, 0, 1, 0, 0, 8'h77, 8'h00, 0, 0, 0);
    cyc(6, 0, 0, 0, 1, 0, 8'h00, 8'h77, 1, 0, 0);

    // Hard reset mid-packet discards stored bytes.
    cyc(7, 0, 0, 1, 0, 1, 8'h81, 8'h00, 0, 0, 0);
    cyc(7, 0, 0, 1, 0, 0, 8'h82, 8'h00, 0, 0, 0);
    cyc(7, 0, 0, 1, 0, 0, 8'h83, 8'h00, 0, 0, 0);
    cyc(7, 1, 0, 1, 0, 0, 8'hDD, 8'h00, 1, 0, 0);
    cyc(7, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
    cyc(7, 0, 0, 1, 0, 0, 8'h35, 8'h00, 0, 0, 0);
    cyc(7, 0, 0, 0, 1, 0, 8'h00, 8'h35, 1, 0, 0);

    write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_scoreboard actual=%0d pending expected=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
